sr_cmd_conditioner: RTL
=======================

# sr_cmd_conditioner

Upstream conditioning stage for the SR flip-flop. It turns raw, asynchronous set and clear requests (push-buttons, external pins) into clean, single-cycle S/R command pulses. It synchronizes and debounces each input, detects rising edges, and arbitrates between set and clear. Its guarantee to the downstream flip-flop is that S and R are never asserted together, so the flip-flop's invalid {S,R}=11 case cannot be reached.

## Interface
Parameters:
- SYNC_STAGES, 2: synchronizer flops per input; legal range 2..4.
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required before a new level is accepted; minimum 1.
- SET_WINS, 0: simultaneous-event winner. 0 means clear wins; 1 means set wins.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: synchronous, active-high. The clock is clk.
- set_req_in  in  1  raw asynchronous set request, active-high.
- clr_req_in  in  1  raw asynchronous clear request, active-high.
- S  out  1  one-cycle set pulse to the flip-flop.
- R  out  1  one-cycle reset pulse to the flip-flop.
- busy  out  1  high while a pulse or its gap cycle is in progress.
- conflict  out  1  one-cycle pulse when set and clear events collide.
- overrun  out  1  one-cycle pulse when an event merges into an identical pending event.

## Operation
Per-input path:
- The raw input passes through a SYNC_STAGES flop chain.
- The debouncer compares the synchronized level with the accepted level. While they differ, a counter (width $clog2(DEBOUNCE_CYCLES+1)) increments. Any cycle in which they are equal clears the counter. When the counter reaches DEBOUNCE_CYCLES, the accepted level takes the synchronized value and the counter clears.
- A 0->1 transition of the accepted level produces a one-cycle event. A 1->0 transition produces no event.

Pending flags set_pend and clr_pend:
- An event sets its flag. The flag clears when its pulse is issued.
- If an event arrives while its own flag is already set, it is merged and overrun pulses.
- If both events arrive in the same cycle, or one arrives while the other flag is set and not yet issued, conflict pulses. Only the winner per SET_WINS stays pending; the loser is discarded.

Output FSM states: IDLE, PULSE_S, PULSE_R, GAP.
- From IDLE, a pending flag moves the FSM to PULSE_S or PULSE_R. An empty flag set keeps it in IDLE.
- PULSE_S drives S=1 for exactly one cycle, then goes to GAP. PULSE_R does the same for R.
- GAP lasts one cycle with S=R=0, then returns to IDLE.
- busy=1 in PULSE_S, PULSE_R and GAP.
- Events arriving during a pulse or gap are latched and issued after the GAP cycle.

Invariants:
- S&R is always 0.
- Consecutive pulses are at least 2 cycles apart.

## Timing
- Reset values: S=0, R=0, busy=0, conflict=0, overrun=0. Reset also clears synchronizers, accepted levels, counters and pending flags, and puts the FSM in IDLE.
- Latency from the first clk edge sampling a new raw level to S or R high, with the FSM idle: SYNC_STAGES + DEBOUNCE_CYCLES + 2 cycles.
- Reset mid-operation aborts any pulse on the next edge, and pending events are lost.
- An input held high through reset release is seen as a fresh rising edge and issues a pulse after the normal latency.
- A glitch shorter than DEBOUNCE_CYCLES cycles produces no event.

## Configuration
- Macro SR_CMD_DEBOUNCE_EN.
- Defined: debouncers are present as described above, and DEBOUNCE_CYCLES applies.
- Undefined: the accepted level equals the synchronized level. DEBOUNCE_CYCLES is ignored, latency is SYNC_STAGES + 2, and no counter logic is generated.

## Structure
- Package sr_cmd_pkg holds:
  - the FSM state enum (IDLE, PULSE_S, PULSE_R, GAP);
  - the SET_WINS encoding constants;
  - a function returning the counter width.
- Sub-module sr_cmd_debounce contains the synchronizer, the debouncer and the rising-edge detector, and outputs a one-cycle event. It is instantiated twice.
- The top level holds the pending flags, arbitration and the FSM.

## Test plan
Unless stated, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, SET_WINS=0, macro defined.
- Clean set: set_req_in held high for 10 cycles -> S=1 for exactly one cycle, 8 cycles after the first sample. R stays 0. busy stays high for 2 cycles.
- Glitch: set_req_in high for 3 cycles, then low -> no S pulse.
- Collision: both inputs rise in the same cycle -> conflict pulses once, R pulses once, S never pulses.
- Back-to-back: the clear event arrives during the S pulse of an earlier set -> R is issued 2 cycles after S, and S&R=0 on every cycle.
- Reset mid-pulse: rst asserted in the PULSE_S cycle -> S=0 on the next edge and all outputs at reset values. With set_req_in still high after rst drops, S pulses again after 8 cycles.
- Macro undefined: the clean set stimulus -> S pulse 4 cycles after the first sample.

Source files
------------

// File: rtl/sr_cmd_pkg.sv
// Shared types and constants for the SR command conditioner.
// Debounce counter sizing lives here so the width rule is defined once.
package sr_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE_S = 2'd1,
        PULSE_R = 2'd2,
        GAP     = 2'd3
    } sr_state_t;

    localparam int SET_WINS_CLEAR = 0;
    localparam int SET_WINS_SET   = 1;

    // Counter must be able to hold DEBOUNCE_CYCLES; never narrower than 1 bit.
    function automatic int cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/sr_cmd_debounce.sv
// One request input: synchronizer, optional debouncer (SR_CMD_DEBOUNCE_EN)
// and rising-edge detector producing a registered one-cycle event.
module sr_cmd_debounce
    import sr_cmd_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic req_in,
    output logic event_out
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_lvl;
    logic                   acc_lvl;
    logic                   acc_prev_q;
    logic                   event_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], req_in};
        end
    end

    assign sync_lvl = sync_q[SYNC_STAGES-1];

`ifdef SR_CMD_DEBOUNCE_EN
    localparam int CW = cnt_width(DEBOUNCE_CYCLES);

    logic [CW-1:0] cnt_q;
    logic          acc_q;

    // Count consecutive cycles of disagreement; the last one flips the level.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            acc_q <= 1'b0;
        end else if (sync_lvl != acc_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                acc_q <= sync_lvl;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end else begin
            cnt_q <= '0;
        end
    end

    assign acc_lvl = acc_q;
`else
    // Without the debouncer the synchronized level is accepted directly.
    if (DEBOUNCE_CYCLES < 1) begin : g_debounce_unused
    end

    assign acc_lvl = sync_lvl;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_prev_q <= 1'b0;
            event_q    <= 1'b0;
        end else begin
            acc_prev_q <= acc_lvl;
            event_q    <= acc_lvl & ~acc_prev_q;
        end
    end

    assign event_out = event_q;

endmodule

// File: rtl/sr_cmd_conditioner.sv
// Turns raw set/clear requests into mutually exclusive one-cycle S/R pulses.
// Debouncing is built only when SR_CMD_DEBOUNCE_EN is defined.
module sr_cmd_conditioner
    import sr_cmd_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SET_WINS        = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic set_req_in,
    input  logic clr_req_in,
    output logic S,
    output logic R,
    output logic busy,
    output logic conflict,
    output logic overrun
);

    localparam bit SET_PRIO = (SET_WINS == SET_WINS_SET);

    logic set_ev;
    logic clr_ev;

    sr_cmd_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_set_db (
        .clk      (clk),
        .rst      (rst),
        .req_in   (set_req_in),
        .event_out(set_ev)
    );

    sr_cmd_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_clr_db (
        .clk      (clk),
        .rst      (rst),
        .req_in   (clr_req_in),
        .event_out(clr_ev)
    );

    sr_state_t state_q;
    sr_state_t state_d;

    logic set_pend_q;
    logic clr_pend_q;
    logic set_pend_d;
    logic clr_pend_d;
    logic issue_s;
    logic issue_r;
    logic set_live;
    logic clr_live;
    logic conflict_d;
    logic overrun_d;
    logic conflict_q;
    logic overrun_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // GAP may hand straight over to the next pulse, keeping pulses two cycles apart.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, GAP: begin
                if (set_pend_q && (SET_PRIO || !clr_pend_q)) begin
                    state_d = PULSE_S;
                end else if (clr_pend_q) begin
                    state_d = PULSE_R;
                end else begin
                    state_d = IDLE;
                end
            end
            PULSE_S, PULSE_R: state_d = GAP;
            default:          state_d = IDLE;
        endcase
    end

    always_comb begin
        S    = 1'b0;
        R    = 1'b0;
        busy = 1'b0;
        case (state_q)
            PULSE_S: begin
                S    = 1'b1;
                busy = 1'b1;
            end
            PULSE_R: begin
                R    = 1'b1;
                busy = 1'b1;
            end
            GAP:     busy = 1'b1;
            default: ;
        endcase
    end

    assign issue_s = (state_d == PULSE_S);
    assign issue_r = (state_d == PULSE_R);

    // A flag being issued this cycle no longer counts as pending for collisions.
    always_comb begin
        set_live   = set_pend_q & ~issue_s;
        clr_live   = clr_pend_q & ~issue_r;
        overrun_d  = (set_ev & set_live) | (clr_ev & clr_live);
        conflict_d = (set_ev & clr_ev) | (set_ev & clr_live) | (clr_ev & set_live);
        if (conflict_d) begin
            set_pend_d = SET_PRIO;
            clr_pend_d = !SET_PRIO;
        end else begin
            set_pend_d = set_live | set_ev;
            clr_pend_d = clr_live | clr_ev;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            set_pend_q <= 1'b0;
            clr_pend_q <= 1'b0;
            conflict_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            set_pend_q <= set_pend_d;
            clr_pend_q <= clr_pend_d;
            conflict_q <= conflict_d;
            overrun_q  <= overrun_d;
        end
    end

    assign conflict = conflict_q;
    assign overrun  = overrun_q;

endmodule
